// File: rtl/gpi_ctrl.sv
// Debounced general-purpose input block: per-pin synchronizer, debounce counter,
// edge-selectable sticky event flags and a masked level interrupt behind a 4-register map.
module gpi_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [6:0] gpi_pins,
  output logic       irq
);

  localparam int         NUM_PINS = 7;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  logic [7:0]          ctrl;
  logic [NUM_PINS-1:0] edge_pol;
  logic [NUM_PINS-1:0] status;
  logic [NUM_PINS-1:0] status_next;
  logic [NUM_PINS-1:0] level;
  logic [NUM_PINS-1:0] level_next;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] event_hit;
  logic [NUM_PINS-1:0] w1c;
  logic [NUM_PINS-1:0] sync_out;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [7:0]          cnt [NUM_PINS];
  logic [7:0]          cnt_next [NUM_PINS];
  logic [7:0]          read_mux;
  logic                enable;

  assign enable   = ctrl[7];
  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain keeps running while disabled so levels are clean at enable time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpi_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    rise       = '0;
    fall       = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (!enable) begin
        cnt_next[i]   = '0;
        level_next[i] = 1'b0;
      end else if (sync_out[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          cnt_next[i]   = '0;
          level_next[i] = ~level[i];
          rise[i]       = ~level[i];
          fall[i]       = level[i];
        end else begin
          cnt_next[i] = cnt[i] + 8'd1;
        end
      end else begin
        cnt_next[i] = '0;
      end
    end
  end

  // A new event overrides a same-cycle write-1-to-clear of its flag.
  always_comb begin
    event_hit   = (rise & ~edge_pol) | (fall & edge_pol);
    w1c         = (wr_en && addr == ADDR_STATUS) ? data_in[NUM_PINS-1:0] : '0;
    status_next = (status & ~w1c) | event_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level  <= '0;
      status <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
    end else begin
      level  <= level_next;
      status <= status_next;
      for (int i = 0; i < NUM_PINS; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl     <= '0;
      edge_pol <= '0;
    end else if (wr_en) begin
      if (addr == ADDR_CTRL) ctrl <= data_in;
      if (addr == ADDR_EDGE) edge_pol <= data_in[NUM_PINS-1:0];
    end
  end

  always_comb begin
    read_mux = '0;
    case (addr)
      ADDR_CTRL:   read_mux = ctrl;
      ADDR_EDGE:   read_mux = {1'b0, edge_pol};
      ADDR_STATUS: read_mux = {1'b0, status};
      ADDR_LEVEL:  read_mux = {1'b0, level};
      default:     read_mux = '0;
    endcase
  end

  // Read data samples pre-write register contents, so read+write returns the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) data_out <= '0;
    else          data_out <= rd_en ? read_mux : 8'h00;
  end

  assign irq = enable & (|(status & ctrl[NUM_PINS-1:0]));

endmodule
